// File: rtl/fifo_umbral.sv
// Circular-buffer FIFO with programmable almost-full/almost-empty thresholds and sticky error flag.
// Optional macro FIFO_UMBRAL_ERRCNT_EN adds a saturating over/underflow event counter (err_count).
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH-1:0] umbral_alto,
  input  logic [ADDR_WIDTH-1:0] umbral_bajo,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  fifo_error,
  output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_UMBRAL_ERRCNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  localparam int                  DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [ADDR_WIDTH-1:0]            wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0]            alto_reg, bajo_reg;
  logic [ADDR_WIDTH:0]              count_nxt;
  logic                             do_push, do_pop, err_event;

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign almost_full  = (count >= {1'b0, alto_reg});
  assign almost_empty = (count <= {1'b0, bajo_reg});

  // A pop frees the slot being written, so push at full is legal with a pop.
  assign do_pop    = pop && !fifo_empty;
  assign do_push   = push && (!fifo_full || pop);
  assign err_event = (push && !pop && fifo_full) || (pop && fifo_empty);

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
      alto_reg   <= ADDR_WIDTH'(DEPTH-1);
      bajo_reg   <= ADDR_WIDTH'(1);
    end else begin
      valid_out <= do_pop;
      if (do_pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      count <= count_nxt;
      if (init) begin
        alto_reg   <= umbral_alto;
        bajo_reg   <= umbral_bajo;
        fifo_error <= err_event;
      end else if (err_event) begin
        fifo_error <= 1'b1;
      end
    end
  end

`ifdef FIFO_UMBRAL_ERRCNT_EN
  // Mirrors fifo_error: init clears, but an error in the same cycle still counts.
  always_ff @(posedge clk) begin
    if (reset)                               err_count <= '0;
    else if (init)                           err_count <= err_event ? 8'd1 : 8'd0;
    else if (err_event && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule
